// File: rtl/tdm_1x4_demux.sv
// Receive side of the 4:1 TDM link: aligns to the slot-0 frame marker and
// rebuilds each 4-slot frame into a parallel word with a one-cycle strobe.
module tdm_1x4_demux #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       serial_in,
  input  logic       sync_in,
  output logic [3:0] out,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LockCnt = 4'(LOCK_FRAMES);

  state_t     r_state;
  logic [1:0] r_slot;
  logic [3:0] r_goodCnt;
  logic [2:0] r_shadow;
  logic [3:0] r_out;
  logic       r_frameValid;
  logic       r_syncErr;

  state_t     w_nextState;
  logic [1:0] w_nextSlot;
  logic [3:0] w_nextCnt;
  logic [2:0] w_nextShadow;
  logic [3:0] w_nextOut;
  logic       w_frameValid;
  logic       w_syncErr;
  logic [3:0] w_cntInc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HUNT;
      r_slot       <= 2'd0;
      r_goodCnt    <= 4'd0;
      r_shadow     <= 3'd0;
      r_out        <= 4'd0;
      r_frameValid <= 1'b0;
      r_syncErr    <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_slot       <= w_nextSlot;
      r_goodCnt    <= w_nextCnt;
      r_shadow     <= w_nextShadow;
      r_out        <= w_nextOut;
      r_frameValid <= w_frameValid;
      r_syncErr    <= w_syncErr;
    end
  end

  // A misplaced marker is not just an error: that beat restarts a frame as slot 0.
  always_comb begin
    w_nextState  = r_state;
    w_nextSlot   = r_slot;
    w_nextCnt    = r_goodCnt;
    w_nextShadow = r_shadow;
    w_nextOut    = r_out;
    w_frameValid = 1'b0;
    w_syncErr    = 1'b0;
    w_cntInc     = (r_goodCnt == LockCnt) ? r_goodCnt : r_goodCnt + 4'd1;

    if (in_valid) begin
      if (r_state == HUNT) begin
        if (sync_in) begin
          w_nextShadow[0] = serial_in;
          w_nextSlot      = 2'd1;
          w_nextState     = CHECK;
          w_nextCnt       = 4'd0;
        end
      end else if (r_slot == 2'd0 && !sync_in) begin
        w_syncErr   = 1'b1;
        w_nextCnt   = 4'd0;
        w_nextState = HUNT;
        w_nextSlot  = 2'd0;
      end else if (r_slot != 2'd0 && sync_in) begin
        w_syncErr       = 1'b1;
        w_nextCnt       = 4'd0;
        w_nextState     = CHECK;
        w_nextShadow[0] = serial_in;
        w_nextSlot      = 2'd1;
      end else begin
        w_nextSlot = r_slot + 2'd1;
        case (r_slot)
          2'd0: w_nextShadow[0] = serial_in;
          2'd1: w_nextShadow[1] = serial_in;
          2'd2: w_nextShadow[2] = serial_in;
          default: begin
            if (r_state == CHECK) begin
              w_nextCnt = w_cntInc;
              if (w_cntInc == LockCnt) begin
                w_nextState  = LOCKED;
                w_nextOut    = {serial_in, r_shadow};
                w_frameValid = 1'b1;
              end
            end else begin
              w_nextOut    = {serial_in, r_shadow};
              w_frameValid = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign out         = r_out;
  assign frame_valid = r_frameValid;
  assign locked      = (r_state == LOCKED);
  assign sync_err    = r_syncErr;

endmodule

// File: tb/tb_tdm_1x4_demux.sv
// Directed bench for tdm_1x4_demux: lock, hunt filtering, gaps, framing
// violations and asynchronous reset, each checked against hand-derived values.
module tb_tdm_1x4_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       serial_in;
  logic       sync_in;
  logic [3:0] out;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  tdm_1x4_demux #(.LOCK_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .serial_in  (serial_in),
    .sync_in    (sync_in),
    .out        (out),
    .frame_valid(frame_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One beat, then settle 1ns past the edge so outputs reflect this beat.
  task automatic applyStimulus(input logic v, input logic d, input logic s);
    in_valid  = v;
    serial_in = d;
    sync_in   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [3:0] word);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, word[k], k == 0);
  endtask

  task automatic checkAll(input string tag, input logic [3:0] expOut, input logic expFv,
                          input logic expLocked, input logic expErr);
    checkOutput({tag, ".out"}, {4'd0, out}, {4'd0, expOut});
    checkOutput({tag, ".fv"}, {7'd0, frame_valid}, {7'd0, expFv});
    checkOutput({tag, ".locked"}, {7'd0, locked}, {7'd0, expLocked});
    checkOutput({tag, ".err"}, {7'd0, sync_err}, {7'd0, expErr});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; serial_in = 1'b0; sync_in = 1'b0;
    #12;
    checkAll("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic lock on 4'b1011
    sendFrame(4'b1011);
    checkAll("lock.f1", 4'b0000, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b1011);
    checkAll("lock.f2", 4'b1011, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkAll("lock.pulse1", 4'b1011, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("lock.f3", 4'b1011, 1'b1, 1'b1, 1'b0);

    // Missing marker drops to HUNT, out holds
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("nomark", 4'b1011, 1'b0, 1'b0, 1'b1);

    // Hunt filtering
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i[0], 1'b0);
      checkOutput("hunt.err", {7'd0, sync_err}, 8'd0);
    end
    sendFrame(4'b0110);
    checkAll("hunt.f1", 4'b1011, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b0110);
    checkAll("hunt.f2", 4'b0110, 1'b1, 1'b1, 1'b0);

    // Gapped frame 4'b1001 with a 3-cycle gap between slots 1 and 2
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkAll("gap.hold", 4'b0110, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("gap.done", 4'b1001, 1'b1, 1'b1, 1'b0);

    // Early marker at slot 2 restarts the frame on that beat
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkAll("early.err", 4'b1001, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("early.f1", 4'b1001, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b1100);
    checkAll("early.f2", 4'b1100, 1'b1, 1'b1, 1'b0);

    // Async reset during slot 2 while locked
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    in_valid = 1'b1; serial_in = 1'b1; sync_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkAll("rst.async", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    // Remaining beats of the interrupted frame must be ignored in HUNT
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("rst.hunt", 4'b0000, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b0101);
    checkAll("rst.f1", 4'b0000, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b0101);
    checkAll("rst.f2", 4'b0101, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_1x4_demux.md
Name: tdm_1x4_demux

Overview:
- Receive side of the 4:1 select-mux path: recovers a 4-bit parallel word from a time-division serial stream.
- Each slot k of the stream carries lane a_in[k], i.e. the mux output with select {s1,s0}=k.
- A frame marker locates slot 0. A hunt/check/lock state machine aligns to the marker, reassembles each frame and publishes the 4-bit word with a one-cycle strobe.
- Sits between the mux/serial link and any consumer of the parallel lanes.

Parameters:
LOCK_FRAMES, 2, consecutive correctly framed frames needed in CHECK before entering LOCKED (legal 1..15).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  current serial_in/sync_in beat is valid; one slot consumed per valid cycle
serial_in  input  1  slot data bit (mux output)
sync_in  input  1  frame marker; high only on the slot-0 beat
out  output  4  last completed frame; out[k] = bit received in slot k
frame_valid  output  1  one-cycle pulse: out updated this cycle
locked  output  1  high while state is LOCKED
sync_err  output  1  one-cycle pulse: framing violation detected

Behaviour:
Reset (async, active-high):
- out=4'b0000, frame_valid=0, locked=0, sync_err=0.
- state=HUNT, slot=0, good_cnt=0, shadow=0.
- Reset mid-frame discards the partial frame.

General rules:
- All state is updated on the rising clk edge and only when in_valid=1.
- With in_valid=0, every register holds, and frame_valid and sync_err drop to 0.
- Gaps may occur at any slot.
- Slot counter: 2 bits, wraps 3->0.
- shadow[slot] <= serial_in on each accepted beat.

HUNT:
- Ignore beats with sync_in=0; sync_err is not asserted.
- Beat with sync_in=1: shadow[0]<=serial_in, slot<=1, go to CHECK, good_cnt<=0.

CHECK / LOCKED, framing check on every accepted beat:
- Slot 0 expects sync_in=1.
- Slots 1..3 expect sync_in=0.
- Violation, sync_in=0 at slot 0:
  - sync_err pulse, locked<=0, good_cnt<=0, go to HUNT, partial frame dropped, out held.
- Violation, sync_in=1 at slot 1..3:
  - sync_err pulse, partial frame dropped, out held, locked<=0, good_cnt<=0.
  - The beat is treated as a new slot 0: shadow[0]<=serial_in, slot<=1, state CHECK.

Frame completion (accepted slot-3 beat with no violation):
- CHECK: good_cnt<=good_cnt+1. If good_cnt+1==LOCK_FRAMES, go to LOCKED, locked<=1, out<={serial_in,shadow[2:0]}, frame_valid<=1. Otherwise stay in CHECK; out is not updated.
- LOCKED: out<={serial_in,shadow[2:0]}, frame_valid<=1.
- Latency: out and frame_valid are visible the cycle after the slot-3 beat edge. frame_valid is exactly one cycle wide.
- A back-to-back slot-0 beat in the next cycle is legal.

Width and arithmetic:
- good_cnt is 4 bits and saturates at LOCK_FRAMES.
- No other arithmetic.

Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset mid-frame:
   - Stimulus: assert reset during slot 2 while locked.
   - Required: out=0, locked=0, frame_valid=0 immediately (async). After release, the stream requires a full re-hunt.
2. Basic lock with word 4'b1011:
   - Stimulus: send slots 0..3 = 1,1,0,1 with sync_in on slot 0, continuous in_valid, LOCK_FRAMES=2.
   - Required: no frame_valid after frame 1. After frame 2: locked=1, out=4'b1011, frame_valid=1 for one cycle.
   - Every later frame pulses frame_valid again.
3. Hunt filtering:
   - Stimulus: 5 beats with sync_in=0, then correct frames of 4'b0110.
   - Required: sync_err stays 0 during hunt. Lock occurs after 2 frames with out=4'b0110.
4. Gapped stream:
   - Stimulus: while locked, insert in_valid=0 for 3 cycles between slots 1 and 2 of frame 4'b1001.
   - Required: out=4'b1001 one cycle after the slot-3 beat. All outputs hold during the gap.
5. Missing marker:
   - Stimulus: while locked, send slot 0 with sync_in=0.
   - Required: sync_err pulse, locked=0, out holds its previous value (e.g. 4'b1011), state returns to HUNT.
6. Early marker:
   - Stimulus: while locked, send sync_in=1 at slot 2, followed by a full frame of 4'b1100 built on that beat.
   - Required: sync_err pulse, locked=0, resync from that beat. Lock is regained after LOCK_FRAMES good frames, with out=4'b1100.
